// File: rtl/mac_sequencer.sv
// Purpose: sequences one signed 32-bit dot product by streaming weight and image memories into an external MAC.
// Latency: done pulses len+3 cycles after the go edge; result is valid from that cycle onward.
// Backpressure: none; a go that arrives while busy is dropped, not queued.
module mac_sequencer #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic [ADDR_W-1:0] len,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] im_base,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] im_addr,
  input  logic [31:0]       w_rdata,
  input  logic [31:0]       im_rdata,
  output logic              mac_start,
  output logic              mac_stop,
  output logic [31:0]       mac_w,
  output logic [31:0]       mac_im,
  input  logic [31:0]       mac_p,
  output logic              busy,
  output logic              done,
  output logic [31:0]       result
);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic              start_req;

  assign start_req = (state == IDLE) && go;

  // State register; reset forces IDLE regardless of the clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and per-state MAC control outputs.
  always_comb begin
    state_nxt = state;
    mac_start = 1'b0;
    mac_stop  = 1'b1;
    mac_w     = 32'd0;
    mac_im    = 32'd0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (go) state_nxt = CLEAR;
      end
      CLEAR: begin
        mac_start = 1'b1;
        state_nxt = (cnt != '0) ? FEED : DRAIN;
      end
      FEED: begin
        mac_stop = 1'b0;
        mac_w    = w_rdata;
        mac_im   = im_rdata;
        if (cnt == ADDR_ONE) state_nxt = DRAIN;
      end
      DRAIN: begin
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Remaining-products counter: loaded with len on start, counts down once per FEED cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (start_req) begin
      cnt <= len;
    end else if (state == FEED) begin
      cnt <= cnt - ADDR_ONE;
    end
  end

  // Read addresses: the bases double as the latched start points; each advances one step
  // per CLEAR/FEED cycle so data lands one cycle ahead of its use. Wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_addr  <= '0;
      im_addr <= '0;
    end else if (start_req) begin
      w_addr  <= w_base;
      im_addr <= im_base;
    end else if (state == CLEAR || state == FEED) begin
      w_addr  <= w_addr + ADDR_ONE;
      im_addr <= im_addr + ADDR_ONE;
    end
  end

  // Capture the accumulator once the final product has been folded in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= 32'd0;
    end else if (state == DRAIN) begin
      result <= mac_p;
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
module tb_mac_sequencer;

  localparam int AW  = 10;
  localparam int MSZ = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          go;
  logic [AW-1:0] len;
  logic [AW-1:0] w_base;
  logic [AW-1:0] im_base;
  logic [AW-1:0] w_addr;
  logic [AW-1:0] im_addr;
  logic [31:0]   w_rdata;
  logic [31:0]   im_rdata;
  logic          mac_start;
  logic          mac_stop;
  logic [31:0]   mac_w;
  logic [31:0]   mac_im;
  logic [31:0]   mac_p;
  logic          busy;
  logic          done;
  logic [31:0]   result;

  int checks = 0;
  int errors = 0;

  logic [31:0] wmem  [MSZ];
  logic [31:0] immem [MSZ];
  logic [31:0] acc;

  mac_sequencer #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .len(len), .w_base(w_base), .im_base(im_base),
    .w_addr(w_addr), .im_addr(im_addr), .w_rdata(w_rdata), .im_rdata(im_rdata),
    .mac_start(mac_start), .mac_stop(mac_stop), .mac_w(mac_w), .mac_im(mac_im),
    .mac_p(mac_p), .busy(busy), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memories: data one cycle after the address.
  always @(posedge clk) begin
    w_rdata  <= wmem[w_addr];
    im_rdata <= immem[im_addr];
  end

  // Downstream accumulator PE.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)         acc <= 32'd0;
    else if (mac_start) acc <= 32'd0;
    else if (!mac_stop) acc <= acc + mac_w * mac_im;
  end
  assign mac_p = acc;

  // Reference dot product: exact signed sum, truncated to 32 bits at the end.
  function automatic logic [31:0] ref_dot(input int l, input int wb, input int ib);
    longint s;
    s = 0;
    for (int k = 0; k < l; k++)
      s += longint'($signed(wmem[(wb + k) % MSZ])) * longint'($signed(immem[(ib + k) % MSZ]));
    return s[31:0];
  endfunction

  // One full operation with per-cycle phase checks. A second go is pulsed at cycle
  // go_again_at (0 = never); it must have no effect.
  task automatic run_op(input int l, input int wb, input int ib, input int go_again_at, input string tag);
    logic [31:0] exp_res;
    logic [3:0]  exp_ctl;  // {busy, done, mac_start, mac_stop}
    logic [3:0]  got_ctl;
    int stop_low;
    int done_cnt;
    int k;
    exp_res  = ref_dot(l, wb, ib);
    stop_low = 0;
    done_cnt = 0;
    @(negedge clk);
    go = 1'b1; len = AW'(l); w_base = AW'(wb); im_base = AW'(ib);
    for (int n = 1; n <= l + 3; n++) begin
      @(negedge clk);
      got_ctl = {busy, done, mac_start, mac_stop};
      if (n == 1)          exp_ctl = 4'b1011;
      else if (n <= l + 1) exp_ctl = 4'b1000;
      else if (n == l + 2) exp_ctl = 4'b1001;
      else                 exp_ctl = 4'b1101;
      checks++;
      if (got_ctl !== exp_ctl) begin
        errors++;
        $display("FAIL %s ctl cycle %0d: got %b want %b", tag, n, got_ctl, exp_ctl);
      end
      if (!mac_stop) stop_low++;
      if (done) done_cnt++;
      if (n <= l + 1) begin
        checks++;
        if (w_addr !== AW'((wb + n - 1) % MSZ) || im_addr !== AW'((ib + n - 1) % MSZ)) begin
          errors++;
          $display("FAIL %s addr cycle %0d: got %0d/%0d want %0d/%0d", tag, n, w_addr, im_addr,
                   (wb + n - 1) % MSZ, (ib + n - 1) % MSZ);
        end
      end
      checks++;
      if (n >= 2 && n <= l + 1) begin
        k = n - 2;
        if (mac_w !== wmem[(wb + k) % MSZ] || mac_im !== immem[(ib + k) % MSZ]) begin
          errors++;
          $display("FAIL %s operands k=%0d: got %h/%h want %h/%h", tag, k, mac_w, mac_im,
                   wmem[(wb + k) % MSZ], immem[(ib + k) % MSZ]);
        end
      end else if (mac_w !== 32'd0 || mac_im !== 32'd0) begin
        errors++;
        $display("FAIL %s operands idle cycle %0d: got %h/%h want 0/0", tag, n, mac_w, mac_im);
      end
      if (n == l + 3) begin
        checks++;
        if (result !== exp_res) begin
          errors++;
          $display("FAIL %s result: got %h want %h", tag, result, exp_res);
        end
      end
      // Scramble inputs after the start so any failure to latch shows up.
      go = (n == go_again_at);
      len = AW'($urandom); w_base = AW'($urandom); im_base = AW'($urandom);
    end
    go = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (n == 0) begin
        checks++;
        if (busy !== 1'b0 || result !== exp_res) begin
          errors++;
          $display("FAIL %s post: busy %b result %h want 0 %h", tag, busy, result, exp_res);
        end
      end
    end
    checks++;
    if (stop_low != l) begin
      errors++;
      $display("FAIL %s feed length: got %0d want %0d", tag, stop_low, l);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL %s done pulses: got %0d want 1", tag, done_cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; go = 1'b0; len = '0; w_base = '0; im_base = '0;
    #2;
    checks++;
    if ({busy, done, mac_start, mac_stop} !== 4'b0001 || mac_w !== 32'd0 || mac_im !== 32'd0 ||
        w_addr !== '0 || im_addr !== '0 || result !== 32'd0) begin
      errors++;
      $display("FAIL reset values: ctl %b w %h im %h wa %0d ia %0d res %h", {busy, done, mac_start, mac_stop},
               mac_w, mac_im, w_addr, im_addr, result);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    wmem[100] = 32'd2;  wmem[101] = -32'sd3; wmem[102] = 32'd4;
    immem[200] = 32'd5; immem[201] = 32'd6;  immem[202] = -32'sd1;
    run_op(3, 100, 200, 0, "basic");
    checks++;
    if (result !== 32'hFFFF_FFF4) begin
      errors++;
      $display("FAIL basic const: got %h want fffffff4", result);
    end
  endtask

  task automatic test_zero_len();
    wmem[300] = 32'd7; immem[400] = 32'd1;
    run_op(1, 300, 400, 0, "prior7");
    run_op(0, 500, 600, 0, "zero_len");
    checks++;
    if (result !== 32'd0) begin
      errors++;
      $display("FAIL zero_len const: got %h want 0", result);
    end
  endtask

  task automatic test_wrap();
    run_op(4, 1022, 1021, 0, "wrap");
  endtask

  task automatic test_overflow();
    wmem[10] = 32'h7FFF_FFFF; wmem[11] = 32'd1;
    immem[20] = 32'd1;        immem[21] = 32'd1;
    run_op(2, 10, 20, 0, "overflow");
    checks++;
    if (result !== 32'h8000_0000) begin
      errors++;
      $display("FAIL overflow const: got %h want 80000000", result);
    end
  endtask

  task automatic test_busy_go();
    run_op(5, 700, 800, 3, "busy_go");
  endtask

  task automatic test_reset_mid_feed();
    wmem[50] = 32'd3; immem[60] = 32'd4;
    @(negedge clk);
    go = 1'b1; len = AW'(5); w_base = AW'(900); im_base = AW'(950);
    @(negedge clk); go = 1'b0;  // CLEAR
    @(negedge clk);             // FEED k=0
    @(negedge clk);             // FEED k=1
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || mac_stop !== 1'b1 || result !== 32'd0 || done !== 1'b0 || mac_w !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: busy %b stop %b res %h done %b w %h want 0 1 0 0 0", busy, mac_stop, result, done, mac_w);
    end
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold %0d: done %b busy %b want 0 0", n, done, busy);
      end
    end
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_after %0d: done %b busy %b want 0 0", n, done, busy);
      end
    end
    run_op(1, 50, 60, 0, "after_reset");
    checks++;
    if (result !== 32'd12) begin
      errors++;
      $display("FAIL after_reset const: got %h want 0000000c", result);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++)
      run_op($urandom_range(0, 12), $urandom_range(0, MSZ - 1), $urandom_range(0, MSZ - 1), 0, "random");
  endtask

  initial begin
    for (int i = 0; i < MSZ; i++) begin
      wmem[i]  = $urandom;
      immem[i] = $urandom;
    end
    test_reset();
    test_basic();
    test_zero_len();
    test_wrap();
    test_overflow();
    test_busy_go();
    test_reset_mid_feed();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
